// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: request and response channels between a producer and regfile_ctrl
interface regfile_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_waddr;
   logic [DATA_W-1:0] req_wdata;
   logic [ADDR_W-1:0] req_raddr1;
   logic [ADDR_W-1:0] req_raddr2;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data1;
   logic [DATA_W-1:0] rsp_data2;
   modport master (
      output req_valid, req_wr, req_waddr, req_wdata, req_raddr1, req_raddr2, rsp_ready,
      input  req_ready, rsp_valid, rsp_data1, rsp_data2
   );
   modport slave (
      input  req_valid, req_wr, req_waddr, req_wdata, req_raddr1, req_raddr2, rsp_ready,
      output req_ready, rsp_valid, rsp_data1, rsp_data2
   );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences regFile strobes for posted writes and dual reads with a response channel
module regfile_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   regfile_ctrl_if.slave     bus,
   output logic              rf_EN,
   output logic              rf_WR,
   output logic              rf_RD,
   output logic [DATA_W-1:0] rf_Ip1,
   output logic [ADDR_W-1:0] rf_sel_i1,
   output logic [ADDR_W-1:0] rf_sel_o1,
   output logic [ADDR_W-1:0] rf_sel_o2,
   input  logic [DATA_W-1:0] rf_Op1,
   input  logic [DATA_W-1:0] rf_Op2,
   output logic [15:0]       op_count
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
   localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);
   state_t            state, state_nxt;
   logic [3:0]        wait_cnt;
   logic              accept, sample, done;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data1, rsp_data2;
   assign bus.req_ready = state == IDLE;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data1 = rsp_data1;
   assign bus.rsp_data2 = rsp_data2;
   always_comb begin
      accept    = bus.req_valid & (state == IDLE);
      sample    = (state == READ) & (wait_cnt == '0);
      done      = (state == WRITE) | ((state == RESP) & bus.rsp_ready);
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? (bus.req_wr ? WRITE : READ) : IDLE;
         WRITE:   state_nxt = IDLE;
         READ:    state_nxt = sample ? RESP : READ;
         RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   end
   // Strobes follow the next state so they are registered yet aligned with WRITE/READ
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_EN     <= 1'b0;
         rf_WR     <= 1'b0;
         rf_RD     <= 1'b0;
         rf_Ip1    <= '0;
         rf_sel_i1 <= '0;
         rf_sel_o1 <= '0;
         rf_sel_o2 <= '0;
         rsp_valid <= 1'b0;
         rsp_data1 <= '0;
         rsp_data2 <= '0;
         wait_cnt  <= '0;
         op_count  <= '0;
      end else begin
         rf_WR     <= state_nxt == WRITE;
         rf_RD     <= state_nxt == READ;
         rf_EN     <= (state_nxt == WRITE) | (state_nxt == READ);
         rsp_valid <= state_nxt == RESP;
         if (accept & bus.req_wr) begin
            rf_Ip1    <= bus.req_wdata;
            rf_sel_i1 <= bus.req_waddr;
         end
         if (accept & !bus.req_wr) begin
            rf_sel_o1 <= bus.req_raddr1;
            rf_sel_o2 <= bus.req_raddr2;
         end
         wait_cnt <= accept ? LAT_M1 : ((state == READ) && (wait_cnt != '0)) ? wait_cnt - 4'd1 : wait_cnt;
         if (sample) begin
            rsp_data1 <= rf_Op1;
            rsp_data2 <= rf_Op2;
         end
         if (done) op_count <= op_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed checks of regfile_ctrl with READ_LAT=1 and READ_LAT=3 against a behavioural regFile
module tb_regfile_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s = 1'b0;
   always #5 clk = ~clk;
   logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
   logic [3:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
   logic [31:0] wdata = '0;
   int passed = 0, total = 0;
   logic        en[2], wr[2], rd[2];
   logic [31:0] ip[2], op1[2], op2[2];
   logic [3:0]  si[2], so1[2], so2[2];
   logic [15:0] cnt[2];
   logic [31:0] mem[2][16] = '{default: '0};
   regfile_ctrl_if b1 ();
   regfile_ctrl_if b3 ();
   assign b1.req_valid  = req_valid & !s;
   assign b3.req_valid  = req_valid & s;
   assign b1.req_wr     = req_wr;
   assign b3.req_wr     = req_wr;
   assign b1.req_waddr  = waddr;
   assign b3.req_waddr  = waddr;
   assign b1.req_wdata  = wdata;
   assign b3.req_wdata  = wdata;
   assign b1.req_raddr1 = raddr1;
   assign b3.req_raddr1 = raddr1;
   assign b1.req_raddr2 = raddr2;
   assign b3.req_raddr2 = raddr2;
   assign b1.rsp_ready  = rsp_ready;
   assign b3.rsp_ready  = rsp_ready;
   wire        rdy = s ? b3.req_ready : b1.req_ready;
   wire        rv  = s ? b3.rsp_valid : b1.rsp_valid;
   wire [31:0] d1  = s ? b3.rsp_data1 : b1.rsp_data1;
   wire [31:0] d2  = s ? b3.rsp_data2 : b1.rsp_data2;
   // Behavioural regFile: synchronous write, combinational read
   always @(posedge clk) for (int k = 0; k < 2; k++) if (en[k] & wr[k]) mem[k][si[k]] <= ip[k];
   assign op1[0] = mem[0][so1[0]];
   assign op2[0] = mem[0][so2[0]];
   assign op1[1] = mem[1][so1[1]];
   assign op2[1] = mem[1][so2[1]];
   regfile_ctrl #(.READ_LAT(1)) u1 (
      .clk(clk), .rst(rst), .bus(b1), .rf_EN(en[0]), .rf_WR(wr[0]), .rf_RD(rd[0]),
      .rf_Ip1(ip[0]), .rf_sel_i1(si[0]), .rf_sel_o1(so1[0]), .rf_sel_o2(so2[0]),
      .rf_Op1(op1[0]), .rf_Op2(op2[0]), .op_count(cnt[0])
   );
   regfile_ctrl #(.READ_LAT(3)) u3 (
      .clk(clk), .rst(rst), .bus(b3), .rf_EN(en[1]), .rf_WR(wr[1]), .rf_RD(rd[1]),
      .rf_Ip1(ip[1]), .rf_sel_i1(si[1]), .rf_sel_o1(so1[1]), .rf_sel_o2(so2[1]),
      .rf_Op1(op1[1]), .rf_Op2(op2[1]), .op_count(cnt[1])
   );
   task automatic test_reset();
      req_valid = 1'b1; req_wr = 1'b1; waddr = 4'd3; wdata = 32'h1111_2222;
      repeat (3) @(negedge clk);
      total++; if ({en[0], wr[0], rd[0], rdy} !== 4'b0001) $display("FAIL reset_hold got=%b exp=0001", {en[0], wr[0], rd[0], rdy}); else passed++;
      rst = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      total++; if ({cnt[0], mem[0][3]} !== 48'h0) $display("FAIL reset_no_accept got=%h exp=0", {cnt[0], mem[0][3]}); else passed++;
   endtask
   task automatic test_write(input logic [3:0] a, input logic [31:0] d, input logic [15:0] c);
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; waddr = a; wdata = d;
      total++; if (rdy !== 1'b1) $display("FAIL wr_ready got=%b exp=1", rdy); else passed++;
      @(negedge clk); req_valid = 1'b0; waddr = ~a; wdata = ~d;
      total++; if ({en[s], wr[s], rd[s], rdy} !== 4'b1100) $display("FAIL wr_strobe got=%b exp=1100", {en[s], wr[s], rd[s], rdy}); else passed++;
      total++; if ({si[s], ip[s]} !== {a, d}) $display("FAIL wr_sel_data got=%h exp=%h", {si[s], ip[s]}, {a, d}); else passed++;
      @(negedge clk);
      total++; if ({en[s], wr[s], rd[s], rdy} !== 4'b0001) $display("FAIL wr_done got=%b exp=0001", {en[s], wr[s], rd[s], rdy}); else passed++;
      total++; if (cnt[s] !== c) $display("FAIL wr_count got=%h exp=%h", cnt[s], c); else passed++;
      total++; if (mem[s][a] !== d) $display("FAIL wr_mem got=%h exp=%h", mem[s][a], d); else passed++;
   endtask
   task automatic test_read(input logic [3:0] a1, input logic [3:0] a2, input logic [31:0] e1,
                            input logic [31:0] e2, input int lat, input logic stall, input logic [15:0] c);
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; raddr1 = a1; raddr2 = a2; rsp_ready = !stall;
      @(negedge clk); req_valid = 1'b0; raddr1 = ~a1; raddr2 = ~a2;
      for (int i = 0; i < lat; i++) begin
         total++; if ({en[s], wr[s], rd[s], rv, rdy} !== 5'b10100) $display("FAIL rd_strobe cyc=%0d got=%b exp=10100", i, {en[s], wr[s], rd[s], rv, rdy}); else passed++;
         total++; if ({so1[s], so2[s]} !== {a1, a2}) $display("FAIL rd_sel got=%h exp=%h", {so1[s], so2[s]}, {a1, a2}); else passed++;
         @(negedge clk);
      end
      total++; if ({en[s], wr[s], rd[s], rv, rdy} !== 5'b00010) $display("FAIL rsp_state got=%b exp=00010", {en[s], wr[s], rd[s], rv, rdy}); else passed++;
      total++; if ({d1, d2} !== {e1, e2}) $display("FAIL rsp_data got=%h exp=%h", {d1, d2}, {e1, e2}); else passed++;
      if (stall) begin
         req_valid = 1'b1; req_wr = 1'b1; waddr = a1; wdata = 32'h0BAD_0BAD;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if ({en[s], wr[s], rd[s], rv, rdy, d1, d2, cnt[s]} !== {5'b00010, e1, e2, c - 16'd1})
               $display("FAIL stall cyc=%0d got=%h exp=%h", i, {en[s], wr[s], rd[s], rv, rdy, d1, d2, cnt[s]}, {5'b00010, e1, e2, c - 16'd1});
            else passed++;
         end
         rsp_ready = 1'b1; req_valid = 1'b0;
      end
      @(negedge clk);
      total++; if ({rv, rdy, cnt[s]} !== {2'b01, c}) $display("FAIL rsp_done got=%h exp=%h", {rv, rdy, cnt[s]}, {2'b01, c}); else passed++;
      total++; if (mem[s][a1] !== e1) $display("FAIL rd_mem_intact got=%h exp=%h", mem[s][a1], e1); else passed++;
   endtask
   task automatic test_reset_mid_write();
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b1; waddr = 4'd7; wdata = 32'h0000_0055;
      @(negedge clk); req_valid = 1'b0;
      total++; if ({en[0], wr[0]} !== 2'b11) $display("FAIL mid_pre got=%b exp=11", {en[0], wr[0]}); else passed++;
      rst = 1'b0;
      #1;
      total++; if ({en[0], wr[0], rd[0], rdy} !== 4'b0001) $display("FAIL mid_async got=%b exp=0001", {en[0], wr[0], rd[0], rdy}); else passed++;
      repeat (5) @(negedge clk);
      total++; if ({en[0], wr[0], rd[0], rv, rdy} !== 5'b00001) $display("FAIL mid_flags got=%b exp=00001", {en[0], wr[0], rd[0], rv, rdy}); else passed++;
      total++; if ({ip[0], si[0], so1[0], so2[0], d1, d2, cnt[0]} !== '0) $display("FAIL mid_values got=%h exp=0", {ip[0], si[0], so1[0], so2[0], d1, d2, cnt[0]}); else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++; if ({cnt[0], mem[0][7]} !== 48'h0) $display("FAIL mid_discard got=%h exp=0", {cnt[0], mem[0][7]}); else passed++;
   endtask
   task automatic test_reset_mid_read();
      @(negedge clk); req_valid = 1'b1; req_wr = 1'b0; raddr1 = 4'd1; raddr2 = 4'd1; rsp_ready = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      total++; if ({en[1], rd[1]} !== 2'b11) $display("FAIL rdrst_pre got=%b exp=11", {en[1], rd[1]}); else passed++;
      rst = 1'b0;
      #1;
      total++; if ({en[1], rd[1], rv, rdy} !== 4'b0001) $display("FAIL rdrst_async got=%b exp=0001", {en[1], rd[1], rv, rdy}); else passed++;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      total++; if ({en[1], rd[1], rv, rdy, cnt[1]} !== {4'b0001, 16'h0}) $display("FAIL rdrst_after got=%h exp=%h", {en[1], rd[1], rv, rdy, cnt[1]}, {4'b0001, 16'h0}); else passed++;
   endtask
   initial begin
      test_reset();
      test_write(4'd0, 32'hABCD_EFAB, 16'd1);
      test_write(4'd1, 32'h0123_4567, 16'd2);
      test_reset_mid_write();
      test_read(4'd0, 4'd1, 32'hABCD_EFAB, 32'h0123_4567, 1, 1'b0, 16'd1);
      test_read(4'd0, 4'd1, 32'hABCD_EFAB, 32'h0123_4567, 1, 1'b1, 16'd2);
      test_read(4'd1, 4'd1, 32'h0123_4567, 32'h0123_4567, 1, 1'b0, 16'd3);
      test_write(4'd2, 32'hDEAD_BEEF, 16'd4);
      test_read(4'd2, 4'd0, 32'hDEAD_BEEF, 32'hABCD_EFAB, 1, 1'b0, 16'd5);
      s = 1'b1;
      test_write(4'd1, 32'h0123_4567, 16'd1);
      test_read(4'd1, 4'd1, 32'h0123_4567, 32'h0123_4567, 3, 1'b0, 16'd2);
      test_reset_mid_read();
      test_read(4'd1, 4'd1, 32'h0123_4567, 32'h0123_4567, 3, 1'b0, 16'd1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
